// File: rtl/demux8_deserializer_if.sv
// Serial-in / byte-out bus of the 8-slot deserializer: bit stream with frame
// marking on the input side, valid/ready byte hand-off and frame status on the output side.
interface demux8_deserializer_if;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic       din_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] slot;
    logic       frame_err;
    logic       err_clr;

    modport master (
        output din, din_valid, frame_start, out_ready, err_clr,
        input  din_ready, data_out, out_valid, slot, frame_err
    );

    modport slave (
        input  din, din_valid, frame_start, out_ready, err_clr,
        output din_ready, data_out, out_valid, slot, frame_err
    );
endinterface

// File: rtl/demux8_deserializer.sv
// Collects eight serial bits into a shadow byte and hands the completed byte off
// through a one-deep valid/ready output register; frame_start restarts a frame.
module demux8_deserializer #(
    parameter int MSB_FIRST = 0
) (
    input logic                  clk,
    input logic                  reset_n,
    demux8_deserializer_if.slave bus
);

    function automatic logic [7:0] map_byte(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                r[i] = b[7-i];
            end
        end
        return r;
    endfunction

    logic [2:0] slot_p0;
    logic [7:0] shadow_p0;
    logic [7:0] byte_p1;
    logic       vld_p1;
    logic       err_p1;

    logic din_ready;
    logic accept;
    logic xfer;
    logic complete;
    logic restart;
    logic err_set;

    // Only the last slot can stall, and only while the previous byte is still held.
    assign din_ready = !((slot_p0 == 3'd7) && vld_p1 && !bus.out_ready);
    assign accept    = bus.din_valid && din_ready;
    assign xfer      = vld_p1 && bus.out_ready;
    assign restart   = accept && bus.frame_start;
    assign complete  = accept && !bus.frame_start && (slot_p0 == 3'd7);
    assign err_set   = restart && (slot_p0 != 3'd0);

    // Stage p0: shadow assembly and slot counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_p0   <= 3'd0;
            shadow_p0 <= 8'h00;
        end else if (restart) begin
            shadow_p0 <= {7'b0, bus.din};
            slot_p0   <= 3'd1;
        end else if (complete) begin
            shadow_p0 <= 8'h00;
            slot_p0   <= 3'd0;
        end else if (accept) begin
            shadow_p0[slot_p0] <= bus.din;
            slot_p0            <= slot_p0 + 3'd1;
        end
    end

    // Stage p1: output byte register, hand-off flag and sticky frame error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_p1 <= 8'h00;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            if (complete) begin
                byte_p1 <= map_byte({bus.din, shadow_p0[6:0]});
                vld_p1  <= 1'b1;
            end else if (xfer) begin
                vld_p1  <= 1'b0;
            end
            // A new error on the same edge as a clear must not be lost.
            if (err_set) begin
                err_p1 <= 1'b1;
            end else if (bus.err_clr) begin
                err_p1 <= 1'b0;
            end
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.data_out  = byte_p1;
    assign bus.out_valid = vld_p1;
    assign bus.slot      = slot_p0;
    assign bus.frame_err = err_p1;

endmodule

// File: doc/demux8_deserializer.md
DEMUX8_DESERIALIZER -- requirements
Module: demux8_deserializer

Interface
REQ-001 Parameter: MSB_FIRST, default 0, meaning 0 = slot k lands in data_out[k], 1 = slot k lands in data_out[7-k].
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 din  input  1  serial data bit.
REQ-005 din_valid  input  1  din qualified this cycle.
REQ-006 frame_start  input  1  marks din as slot 0 of a new frame; meaningful only with din_valid.
REQ-007 din_ready  output  1  block can accept din this cycle.
REQ-008 data_out  output  8  assembled byte.
REQ-009 out_valid  output  1  data_out holds an unconsumed byte.
REQ-010 out_ready  input  1  consumer takes data_out this cycle.
REQ-011 slot  output  3  index of next slot to fill, 0..7.
REQ-012 frame_err  output  1  sticky: frame_start seen mid-frame.
REQ-013 err_clr  input  1  clears frame_err.

Function
REQ-014 accept = din_valid && din_ready; transfer out = out_valid && out_ready; no other qualifiers.
REQ-015 On accept without frame_start: din written to shadow bit [slot]; slot increments modulo 8 (7 wraps to 0).
REQ-016 On accept with frame_start: shadow cleared, din written to shadow bit 0, slot becomes 1; if slot was nonzero, frame_err set and partial frame discarded.
REQ-017 frame_start without din_valid ignored; slot and shadow unchanged.
REQ-018 Accept at slot 7 (no frame_start): data_out loaded with {din, shadow[6:0]} mapped per MSB_FIRST, out_valid set, slot to 0, shadow cleared -- all on same edge.
REQ-019 Latency: completed byte visible on data_out/out_valid immediately after the edge accepting its 8th bit.
REQ-020 out_valid stays 1 and data_out stays stable until a transfer; transfer edge clears out_valid.
REQ-021 Transfer and completion on same edge: out_valid remains 1, data_out takes new byte.
REQ-022 din_ready = NOT(slot==7 AND out_valid AND NOT out_ready); combinational from registered state and out_ready; slots 0-6 never stall.
REQ-023 Accept at slot 7 with frame_start: treated as REQ-016 (restart, frame_err set), no byte produced.
REQ-024 err_clr clears frame_err at edge; simultaneous set condition wins, frame_err stays 1.
REQ-025 din_valid low: no state change except out_valid/frame_err per REQ-020/024.

Reset
REQ-026 reset_n low asynchronously forces slot=0, shadow=0, data_out=0x00, out_valid=0, frame_err=0; din_ready reads 1.
REQ-027 Reset mid-frame or with byte pending discards both; no partial byte ever emitted.
REQ-028 First rising edge with reset_n high operates normally; accept on that edge is honoured.

Verification
REQ-029 MSB_FIRST=0, out_ready=1, 8 consecutive accepts din=1,0,1,1,0,0,1,0 with frame_start on first -> data_out=0x4D, out_valid high one cycle, slot back to 0, frame_err=0.
REQ-030 out_ready=0, byte pending, feed 7 bits then 8th -> slots 0-6 accepted, din_ready=0 at slot 7, data_out unchanged; raise out_ready -> 8th bit accepted, new byte appears, out_valid stays 1.
REQ-031 Accept 3 bits, then frame_start with din=1 -> slot=1, frame_err=1, no byte; 7 more bits all 0 -> data_out=0x01; err_clr pulse -> frame_err=0.
REQ-032 err_clr coincident with another mid-frame frame_start -> frame_err remains 1.
REQ-033 MSB_FIRST=1, bits 1,0,0,0,0,0,0,0 -> data_out=0x80.
REQ-034 reset_n low asynchronously at slot 5 with byte pending -> all outputs zero without clock edge; next 8 bits produce a clean byte.
